video_wr_burst_master: RTL and testbench



---
 rtl/video_wr_burst_master_pkg.sv | 22 ++
 rtl/video_wr_burst_master_sync_fifo.sv | 65 ++++++
 rtl/video_wr_burst_master.sv | 215 +++++++++++++++++++++
 tb/tb_video_wr_burst_master.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_wr_burst_master_pkg.sv
// Shared AXI encodings, the AW FSM state type and the AxSIZE helper for the
// video write burst master.
package video_axi_pkg;

    // A burst may never cross this byte boundary.
    localparam int AXI_4K = 4096;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        AW_IDLE,
        AW_SEND,
        AW_SPLIT
    } aw_state_t;

    // AxSIZE encoding for a bus of the given width in bits.
    function automatic logic [2:0] axsize(input int width);
        return 3'($clog2(width / 8));
    endfunction

endpackage

// File: rtl/video_wr_burst_master_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is readable
// combinationally whenever empty is low; pop advances to the next entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]    wptr;
    logic [IW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
        return (p == IW'(DEPTH - 1)) ? '0 : p + IW'(1);
    endfunction

    // Storage write.
    // NOTE: the data array has no reset; emptiness is tracked by count, so
    // stale entries are never observed and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking.
    // NOTE: all sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= next_ptr(wptr);
            if (do_pop)  rptr <= next_ptr(rptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/video_wr_burst_master.sv
// AXI4 write master: queues burst commands, splits them at 4 KB boundaries,
// issues AW with a bounded number outstanding, generates WLAST from the
// queued sub-burst lengths and tracks B responses.
module video_wr_burst_master
    import video_axi_pkg::*;
#(
    parameter int         AXI_DATA_WIDTH  = 128,
    parameter int         AXI_ADDR_WIDTH  = 32,
    parameter logic [3:0] AXI_ID          = 4'd0,
    parameter int         CMD_DEPTH       = 16,
    parameter int         MAX_OUTSTANDING = 8
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    input  logic                              i_cmd_valid,
    output logic                              o_cmd_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]         i_cmd_addr,
    input  logic [7:0]                        i_cmd_len,
    input  logic                              i_wdata_valid,
    output logic                              o_wdata_ready,
    input  logic [AXI_DATA_WIDTH-1:0]         i_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]       i_wstrb,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0]         m_axi_awaddr,
    output logic [7:0]                        m_axi_awlen,
    output logic [3:0]                        m_axi_awid,
    output logic [2:0]                        m_axi_awsize,
    output logic [1:0]                        m_axi_awburst,
    output logic                              m_axi_awlock,
    output logic [3:0]                        m_axi_awcache,
    output logic [2:0]                        m_axi_awprot,
    output logic [3:0]                        m_axi_awqos,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]         m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]       m_axi_wstrb,
    output logic                              m_axi_wlast,
    input  logic                              m_axi_bvalid,
    input  logic [1:0]                        m_axi_bresp,
    input  logic [3:0]                        m_axi_bid,
    output logic                              m_axi_bready,
    output logic [$clog2(MAX_OUTSTANDING):0]  o_outstanding,
    output logic                              o_busy,
    output logic                              o_bresp_err,
    output logic                              o_align_err,
    input  logic                              i_err_clr
);

    localparam int SH = $clog2(AXI_DATA_WIDTH / 8);
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PW = AXI_ADDR_WIDTH - 12;
    localparam int CW = AXI_ADDR_WIDTH + 8;

    aw_state_t                 aw_state;
    logic                      cmd_ready_en;
    logic                      cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic [CW-1:0]             cmd_wdata, cmd_rdata;
    logic                      len_push, len_pop, len_full, len_empty;
    logic [7:0]                len_rdata;
    logic [AXI_ADDR_WIDTH-1:0] rem_addr, src_addr, next_addr;
    logic [7:0]                rem_len, src_len, first_len, next_len;
    logic                      rem_pending, need_split, aw_load;
    logic [12:0]               room;
    logic [8:0]                len_p1;
    logic                      w_active, w_hs;
    logic [7:0]                w_len, w_cnt;
    logic                      aw_hs, b_hs;
    logic                      unused_bid;

    // Commands are stored with the sub-beat address bits already cleared.
    assign cmd_wdata   = {i_cmd_addr[AXI_ADDR_WIDTH-1:SH], {SH{1'b0}}, i_cmd_len};
    assign o_cmd_ready = cmd_ready_en && !cmd_full;
    assign cmd_push    = i_cmd_valid && o_cmd_ready;
    assign cmd_pop     = aw_load && (aw_state == AW_IDLE);
    assign len_push    = aw_load;

    sync_fifo #(.WIDTH(CW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk(i_clk), .rst_n(i_reset_n), .push(cmd_push), .wdata(cmd_wdata),
        .pop(cmd_pop), .rdata(cmd_rdata), .full(cmd_full), .empty(cmd_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(MAX_OUTSTANDING)) u_len_fifo (
        .clk(i_clk), .rst_n(i_reset_n), .push(len_push), .wdata(first_len),
        .pop(len_pop), .rdata(len_rdata), .full(len_full), .empty(len_empty)
    );

    // Size the next sub-burst so it stops at the 4 KB boundary; remainders
    // are re-evaluated the same way, so wide buses may split several times.
    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        src_addr = rem_addr;
        src_len  = rem_len;
        if (aw_state == AW_IDLE) begin
            src_addr = cmd_rdata[CW-1:8];
            src_len  = cmd_rdata[7:0];
        end
        room       = (13'(AXI_4K) - {1'b0, src_addr[11:0]}) >> SH;
        len_p1     = {1'b0, src_len} + 9'd1;
        need_split = ({4'b0, len_p1} > room);
        first_len  = need_split ? 8'(room - 13'd1) : src_len;
        next_addr  = {src_addr[AXI_ADDR_WIDTH-1:12] + PW'(1), 12'h000};
        next_len   = src_len - 8'(room);
    end

    assign aw_load = (((aw_state == AW_IDLE) && !cmd_empty) || (aw_state == AW_SPLIT))
                     && (o_outstanding < OW'(MAX_OUTSTANDING)) && !len_full;

    // AW FSM with registered channel outputs held until awready.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            aw_state      <= AW_IDLE;
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awlen   <= '0;
            rem_pending   <= 1'b0;
            rem_addr      <= '0;
            rem_len       <= '0;
        end else begin
            case (aw_state)
                AW_IDLE, AW_SPLIT: begin
                    if (aw_load) begin
                        m_axi_awvalid <= 1'b1;
                        m_axi_awaddr  <= src_addr;
                        m_axi_awlen   <= first_len;
                        rem_pending   <= need_split;
                        rem_addr      <= next_addr;
                        rem_len       <= next_len;
                        aw_state      <= AW_SEND;
                    end
                end
                AW_SEND: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        aw_state      <= rem_pending ? AW_SPLIT : AW_IDLE;
                    end
                end
                default: aw_state <= AW_IDLE;
            endcase
        end
    end

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign b_hs  = m_axi_bvalid && (o_outstanding != '0);

    // Outstanding AW count: up on AW, down on B, unchanged when both occur.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_outstanding <= '0;
        end else if (aw_hs && !b_hs) begin
            o_outstanding <= o_outstanding + OW'(1);
        end else if (b_hs && !aw_hs) begin
            o_outstanding <= o_outstanding - OW'(1);
        end
    end

    // W engine: stream passes straight through while a sub-burst is active.
    assign m_axi_wvalid  = w_active && i_wdata_valid;
    assign o_wdata_ready = w_active && m_axi_wready;
    assign m_axi_wdata   = i_wdata;
    assign m_axi_wstrb   = i_wstrb;
    assign m_axi_wlast   = w_active && (w_cnt == w_len);
    assign w_hs          = m_axi_wvalid && m_axi_wready;
    assign len_pop       = !len_empty && (!w_active || (w_hs && m_axi_wlast));

    // Beat counter; chains straight into the next length when one is queued.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            w_active <= 1'b0;
            w_len    <= '0;
            w_cnt    <= '0;
        end else if (len_pop) begin
            w_active <= 1'b1;
            w_len    <= len_rdata;
            w_cnt    <= '0;
        end else if (w_hs) begin
            if (m_axi_wlast) begin
                w_active <= 1'b0;
                w_cnt    <= '0;
            end else begin
                w_cnt <= w_cnt + 8'd1;
            end
        end
    end

    // Sticky error flags and post-reset command acceptance; a new error
    // takes priority over a clear in the same cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cmd_ready_en <= 1'b0;
            o_bresp_err  <= 1'b0;
            o_align_err  <= 1'b0;
        end else begin
            cmd_ready_en <= 1'b1;
            if (m_axi_bvalid && (m_axi_bresp != RESP_OKAY)) o_bresp_err <= 1'b1;
            else if (i_err_clr)                            o_bresp_err <= 1'b0;
            if (cmd_push && (|i_cmd_addr[SH-1:0]))          o_align_err <= 1'b1;
            else if (i_err_clr)                            o_align_err <= 1'b0;
        end
    end

    assign o_busy = !cmd_empty || (aw_state != AW_IDLE) || w_active || !len_empty
                    || (o_outstanding != '0);

    assign m_axi_awid    = AXI_ID;
    assign m_axi_awsize  = axsize(AXI_DATA_WIDTH);
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'd0;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_awqos   = 4'd0;
    assign m_axi_bready  = 1'b1;
    assign unused_bid    = &{1'b0, m_axi_bid};

endmodule

// File: tb/tb_video_wr_burst_master.sv
// Directed bench for video_wr_burst_master (128-bit bus, 2 outstanding).
module tb_video_wr_burst_master;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid, cmd_ready;
    logic [31:0]  cmd_addr;
    logic [7:0]   cmd_len;
    logic         wd_valid, wd_ready;
    logic [127:0] wd;
    logic [15:0]  ws;
    logic         awvalid, awready, awlock, wvalid, wready, wlast;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [3:0]   awid, awcache, awqos, bid;
    logic [2:0]   awsize, awprot;
    logic [1:0]   awburst, bresp;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         bvalid, bready;
    logic [1:0]   outstanding;
    logic         busy, bresp_err, align_err, err_clr;

    always #5 clk = ~clk;

    video_wr_burst_master #(
        .AXI_DATA_WIDTH(128), .AXI_ADDR_WIDTH(32), .AXI_ID(4'd0),
        .CMD_DEPTH(4), .MAX_OUTSTANDING(2)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
        .i_wdata_valid(wd_valid), .o_wdata_ready(wd_ready),
        .i_wdata(wd), .i_wstrb(ws),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
        .m_axi_awlen(awlen), .m_axi_awid(awid), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
        .m_axi_awprot(awprot), .m_axi_awqos(awqos),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
        .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_bvalid(bvalid), .m_axi_bresp(bresp), .m_axi_bid(bid),
        .m_axi_bready(bready),
        .o_outstanding(outstanding), .o_busy(busy),
        .o_bresp_err(bresp_err), .o_align_err(align_err), .i_err_clr(err_clr)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        int          n_aw;
        logic [31:0] a0;
        logic [7:0]  l0;
        logic [31:0] a1;
        logic [7:0]  l1;
        logic        align;
        logic        bp;
    } vec_t;

    typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [127:0] data; logic last; } w_t;

    aw_t  aw_q[$];
    w_t   w_q[$];
    vec_t vecs[8];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   b_pending = 0;
    logic b_hold = 1'b0;
    logic bp = 1'b0;
    logic [1:0] resp_val = 2'b00;
    logic data_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave ready generation: always ready, or random stalls under backpressure.
    initial forever begin
        @(posedge clk); #1;
        if (bp) begin
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
        end else begin
            awready = 1'b1;
            wready  = 1'b1;
        end
    end

    // B responder: one response per observed AW unless held off.
    initial forever begin
        @(posedge clk); #1;
        if (!b_hold) begin
            if (b_pending > 0 && rst_n) begin
                bvalid = 1'b1;
                bresp  = resp_val;
                b_pending--;
            end else begin
                bvalid = 1'b0;
                bresp  = 2'b00;
            end
        end
    end

    // Channel monitors sampled mid-cycle; AW must hold steady while stalled.
    initial begin
        logic        prev_pend = 1'b0;
        logic [31:0] prev_addr = '0;
        logic [7:0]  prev_len  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_pend = 1'b0;
            end else begin
                if (prev_pend)
                    check("aw_stable", {23'd0, awvalid, awaddr, awlen}, {23'd0, 1'b1, prev_addr, prev_len});
                if (awvalid && awready) begin
                    aw_q.push_back('{awaddr, awlen});
                    b_pending++;
                end
                if (wvalid && wready) w_q.push_back('{wdata, wlast});
                prev_pend = awvalid && !awready;
                prev_addr = awaddr;
                prev_len  = awlen;
            end
        end
    end

    task automatic send_cmd(input logic [31:0] a, input logic [7:0] l);
        int t = 0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            t++;
            if (t > 2000) begin check("cmd_timeout", 1, 0); break; end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_data(input int n, input logic [127:0] base);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            wd_valid = 1'b1;
            wd = base + 128'(i);
            forever begin
                @(negedge clk);
                if (wd_ready) break;
                t++;
                if (t > 2000) begin check("data_timeout", 1, 0); break; end
            end
            @(posedge clk); #1;
        end
        wd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            t++;
            if (t > 3000) begin check("idle_timeout", 1, 0); break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [127:0] base = 128'(idx + 1) << 64;
        int data_err = 0;
        int last_err = 0;
        aw_q.delete();
        w_q.delete();
        bp = v.bp;
        fork
            send_cmd(v.addr, v.len);
            send_data(int'(v.len) + 1, base);
        join
        wait_idle();
        bp = 1'b0;
        check($sformatf("v%0d_aw_count", idx), aw_q.size(), v.n_aw);
        if (aw_q.size() > 0) begin
            check($sformatf("v%0d_aw0_addr", idx), aw_q[0].addr, v.a0);
            check($sformatf("v%0d_aw0_len", idx), aw_q[0].len, v.l0);
        end
        if (v.n_aw > 1 && aw_q.size() > 1) begin
            check($sformatf("v%0d_aw1_addr", idx), aw_q[1].addr, v.a1);
            check($sformatf("v%0d_aw1_len", idx), aw_q[1].len, v.l1);
        end
        check($sformatf("v%0d_beats", idx), w_q.size(), int'(v.len) + 1);
        for (int i = 0; i < w_q.size(); i++) begin
            if (w_q[i].data !== base + 128'(i)) data_err++;
            if (w_q[i].last !== ((i == int'(v.l0)) || (i == int'(v.len)))) last_err++;
        end
        check($sformatf("v%0d_data_order", idx), data_err, 0);
        check($sformatf("v%0d_wlast_pos", idx), last_err, 0);
        check($sformatf("v%0d_align_err", idx), align_err, v.align);
        check($sformatf("v%0d_outstanding", idx), outstanding, 0);
        if (v.align) begin
            pulse_clr();
            check($sformatf("v%0d_align_clr", idx), align_err, 0);
        end
    endtask

    initial begin
        int beats;
        logic hs;
        logic [127:0] base;

        //            addr          len  n  a0            l0   a1            l1   al    bp
        vecs[0] = '{32'h0000_1000, 8'd15,  1, 32'h0000_1000, 8'd15,  32'h0,         8'd0,   1'b0, 1'b0};
        vecs[1] = '{32'h0000_0FC0, 8'd7,   2, 32'h0000_0FC0, 8'd3,   32'h0000_1000, 8'd3,   1'b0, 1'b0};
        vecs[2] = '{32'h0000_2000, 8'd0,   1, 32'h0000_2000, 8'd0,   32'h0,         8'd0,   1'b0, 1'b0};
        vecs[3] = '{32'h0000_2FF0, 8'd1,   2, 32'h0000_2FF0, 8'd0,   32'h0000_3000, 8'd0,   1'b0, 1'b0};
        vecs[4] = '{32'h0000_3F00, 8'd15,  1, 32'h0000_3F00, 8'd15,  32'h0,         8'd0,   1'b0, 1'b1};
        vecs[5] = '{32'h0000_1004, 8'd3,   1, 32'h0000_1000, 8'd3,   32'h0,         8'd0,   1'b1, 1'b0};
        vecs[6] = '{32'h0000_5000, 8'd255, 1, 32'h0000_5000, 8'd255, 32'h0,         8'd0,   1'b0, 1'b1};
        vecs[7] = '{32'h0000_5800, 8'd255, 2, 32'h0000_5800, 8'd127, 32'h0000_6000, 8'd127, 1'b0, 1'b1};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        wd_valid = 1'b0; wd = '0; ws = '1; awready = 1'b1; wready = 1'b1;
        bvalid = 1'b0; bresp = 2'b00; bid = 4'd0; err_clr = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_awvalid", awvalid, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_awlen", awlen, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_wlast", wlast, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_wdata_ready", wd_ready, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_busy", busy, 0);
        check("rst_errs", {bresp_err, align_err}, 0);
        check("const_awsize", awsize, 4);
        check("const_awburst", awburst, 1);
        check("const_awid_bready", {awid, bready}, 5'b0_0001);
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("cmd_ready_after_rst", cmd_ready, 1);

        // Table-driven bursts.
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Outstanding limit with B withheld.
        aw_q.delete(); w_q.delete();
        b_hold = 1'b1; data_done = 1'b0;
        fork
            begin send_data(4, 128'hABC0); data_done = 1'b1; end
        join_none
        for (int i = 0; i < 4; i++) send_cmd(32'h8000 + 32'(i * 16), 8'd0);
        repeat (20) @(posedge clk); #1;
        check("lim_aw_count", aw_q.size(), 2);
        check("lim_outstanding", outstanding, 2);
        check("lim_awvalid_held", awvalid, 0);
        // Single SLVERR B coinciding with a clear: the set must win.
        bvalid = 1'b1; bresp = 2'b10; err_clr = 1'b1; b_pending--;
        @(posedge clk); #1;
        bvalid = 1'b0; bresp = 2'b00; err_clr = 1'b0;
        @(negedge clk);
        check("lim_after_b_outstanding", outstanding, 1);
        check("lim_after_b_awvalid0", awvalid, 0);
        check("set_wins_over_clr", bresp_err, 1);
        @(negedge clk);
        check("lim_third_aw_2cyc", awvalid, 1);
        @(posedge clk); #1;
        b_hold = 1'b0;
        for (int t = 0; t < 2000 && !(data_done && !busy); t++) @(posedge clk);
        #1;
        check("lim_drained", {31'd0, data_done, busy}, 2);
        check("lim_aw_total", aw_q.size(), 4);
        check("lim_beats", w_q.size(), 4);
        check("lim_outstanding_end", outstanding, 0);
        pulse_clr();
        check("bresp_clr_a", bresp_err, 0);

        // BRESP error is sticky until cleared.
        resp_val = 2'b10;
        run_vec('{32'h0000_A000, 8'd3, 1, 32'h0000_A000, 8'd3, 32'h0, 8'd0, 1'b0, 1'b0}, 10);
        check("bresp_err_set", bresp_err, 1);
        resp_val = 2'b00;
        run_vec('{32'h0000_B000, 8'd1, 1, 32'h0000_B000, 8'd1, 32'h0, 8'd0, 1'b0, 1'b0}, 11);
        check("bresp_err_sticky", bresp_err, 1);
        pulse_clr();
        check("bresp_err_clr", bresp_err, 0);

        // Reset in the middle of a 16-beat burst.
        aw_q.delete(); w_q.delete();
        send_cmd(32'h0000_9000, 8'd15);
        base = 128'h5500;
        wd_valid = 1'b1; wd = base; beats = 0;
        for (int t = 0; t < 500 && beats < 4; t++) begin
            @(negedge clk);
            hs = wd_ready;
            @(posedge clk); #1;
            if (hs) begin beats++; wd = base + 128'(beats); end
        end
        check("mid_beats_before_rst", beats, 4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_aw", {awvalid, awaddr, awlen}, 0);
        check("mid_rst_w", {wvalid, wlast, wd_ready}, 0);
        check("mid_rst_status", {cmd_ready, busy, outstanding}, 0);
        wd_valid = 1'b0; b_pending = 0; bvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        run_vec('{32'h0000_C000, 8'd15, 1, 32'h0000_C000, 8'd15, 32'h0, 8'd0, 1'b0, 1'b1}, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
